connect4_ctrl: RTL and testbench

- Turn sequencer for the 7-column x 6-row connect-four board.
- Owns the 98-bit board register, accepts column-drop requests and computes the landing cell.
- Writes the landing cell, drives the win checker `terminate` (instantiated inside), and decides the outcome of each move: win, draw or next turn.
- Sits between the button/input debouncer and the VGA/LED display logic.

---
 rtl/connect4_pkg.sv | 13 +
 rtl/terminate.sv | 35 +++
 rtl/connect4_ctrl.sv | 131 +++++++++++++
 tb/tb_connect4_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// connect4_pkg: piece codes, board geometry, controller states and cell indexing
package connect4_pkg;
    localparam logic [1:0] PLAYER_A = 2'b10;
    localparam logic [1:0] PLAYER_B = 2'b01;
    localparam logic [1:0] EMPTY    = 2'b00;
    localparam int NUM_COLS   = 7;
    localparam int NUM_ROWS   = 6;
    localparam int ROW_STRIDE = 14;
    typedef enum logic [1:0] {WAIT_MOVE, CHECK_WAIT, CHECK, GAME_OVER} state_t;
    function automatic logic [6:0] cell_idx(input logic [2:0] h, input logic [2:0] c);
        return 7'(ROW_STRIDE * int'(h) + 2 * int'(c) + 1);
    endfunction
endpackage

// File: rtl/terminate.sv
// terminate: registers whether the piece at location completes a four-in-a-row
module terminate
    import connect4_pkg::*;
(
    input  logic        clk,
    input  logic [97:0] grid,
    input  logic [6:0]  location,
    output logic        term,
    output logic [1:0]  winner
);
    logic [1:0] piece;
    logic       hit;
    assign piece = grid[location -: 2];
    function automatic logic run4(input logic [97:0] g, input logic [1:0] p,
                                  input int h, input int c, input int dh, input int dc);
        run4 = 1'b1;
        for (int k = 0; k < 4; k++)
            run4 = run4 & (g[7'(ROW_STRIDE * (h + k * dh) + 2 * (c + k * dc)) +: 2] == p);
    endfunction
    // Earlier moves never won, so any line of the new piece's colour must pass through it.
    always_comb begin
        hit = 1'b0;
        for (int h = 0; h < NUM_ROWS; h++)
            for (int c = 0; c < NUM_COLS; c++) begin
                if (c <= 3 && run4(grid, piece, h, c, 0, 1)) hit = 1'b1;
                if (h <= 2 && run4(grid, piece, h, c, 1, 0)) hit = 1'b1;
                if (h <= 2 && c <= 3 && run4(grid, piece, h, c, 1, 1)) hit = 1'b1;
                if (h <= 2 && c >= 3 && run4(grid, piece, h, c, 1, -1)) hit = 1'b1;
            end
    end
    always_ff @(posedge clk) begin
        term   <= hit && piece != EMPTY;
        winner <= piece;
    end
endmodule

// File: rtl/connect4_ctrl.sv
// connect4_ctrl: turn sequencer owning the board, landing-cell logic and game outcome
module connect4_ctrl
    import connect4_pkg::*;
#(
    parameter int TURN_TIMEOUT = 0,
    parameter int MAX_MOVES    = 42
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [2:0]  move_col,
    output logic        move_ready,
    output logic [97:0] grid,
    output logic [6:0]  location,
    output logic [1:0]  cur_player,
    output logic        illegal,
    output logic        timeout,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        draw,
    output logic [5:0]  move_count
);
    localparam int TW = TURN_TIMEOUT > 1 ? $clog2(TURN_TIMEOUT) : 1;
    state_t      state_q;
    logic [97:0] grid_q;
    logic [6:0]  location_q;
    logic [2:0]  height_q [NUM_COLS];
    logic [5:0]  move_count_q;
    logic [1:0]  cur_player_q, winner_q, next_player;
    logic        illegal_q, timeout_q, game_over_q, draw_q;
    logic [TW-1:0] tcnt_q;
    logic [2:0]  col_h;
    logic [6:0]  new_idx;
    logic        legal, term;
    logic [1:0]  term_win;
    // Legality comes from the height registers alone; an out-of-range column reads as full.
    assign col_h       = move_col < 3'(NUM_COLS) ? height_q[move_col] : 3'(NUM_ROWS);
    assign legal       = col_h != 3'(NUM_ROWS);
    assign new_idx     = cell_idx(col_h, move_col);
    assign next_player = cur_player_q == PLAYER_A ? PLAYER_B : PLAYER_A;
    terminate u_term (
        .clk      (clk),
        .grid     (grid_q),
        .location (location_q),
        .term     (term),
        .winner   (term_win)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_MOVE;
            grid_q       <= '0;
            location_q   <= '0;
            for (int i = 0; i < NUM_COLS; i++) height_q[i] <= '0;
            move_count_q <= '0;
            cur_player_q <= PLAYER_A;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            draw_q       <= 1'b0;
            winner_q     <= EMPTY;
            tcnt_q       <= '0;
        end else if (new_game) begin
            state_q      <= WAIT_MOVE;
            grid_q       <= '0;
            location_q   <= '0;
            for (int i = 0; i < NUM_COLS; i++) height_q[i] <= '0;
            move_count_q <= '0;
            cur_player_q <= PLAYER_A;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            draw_q       <= 1'b0;
            winner_q     <= EMPTY;
            tcnt_q       <= '0;
        end else begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                WAIT_MOVE: begin
                    if (move_valid && legal) begin
                        grid_q[new_idx -: 2] <= cur_player_q;
                        location_q           <= new_idx;
                        height_q[move_col]   <= col_h + 3'd1;
                        move_count_q         <= move_count_q + 6'd1;
                        tcnt_q               <= '0;
                        state_q              <= CHECK_WAIT;
                    end else begin
                        illegal_q <= move_valid;
                        if (TURN_TIMEOUT > 0) begin
                            if (tcnt_q == TW'(TURN_TIMEOUT - 1)) begin
                                timeout_q    <= 1'b1;
                                cur_player_q <= next_player;
                                tcnt_q       <= '0;
                            end else begin
                                tcnt_q <= tcnt_q + 1'b1;
                            end
                        end
                    end
                end
                CHECK_WAIT: state_q <= CHECK;
                CHECK: begin
                    if (term) begin
                        game_over_q <= 1'b1;
                        winner_q    <= term_win;
                        state_q     <= GAME_OVER;
                    end else if (move_count_q == 6'(MAX_MOVES)) begin
                        game_over_q <= 1'b1;
                        draw_q      <= 1'b1;
                        winner_q    <= EMPTY;
                        state_q     <= GAME_OVER;
                    end else begin
                        cur_player_q <= next_player;
                        state_q      <= WAIT_MOVE;
                    end
                end
                GAME_OVER: state_q <= GAME_OVER;
            endcase
        end
    end
    assign move_ready = state_q == WAIT_MOVE;
    assign grid       = grid_q;
    assign location   = location_q;
    assign cur_player = cur_player_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign draw       = draw_q;
    assign move_count = move_count_q;
endmodule

// File: tb/tb_connect4_ctrl.sv
// tb_connect4_ctrl: table-driven games checked move by move against a board model
module tb_connect4_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [2:0]  move_col = 3'd0;
    logic        move_ready, illegal, timeout, game_over, draw;
    logic [97:0] grid;
    logic [6:0]  location;
    logic [1:0]  cur_player, winner;
    logic [5:0]  move_count;

    connect4_ctrl #(.TURN_TIMEOUT(16), .MAX_MOVES(42)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_col   (move_col),
        .move_ready (move_ready),
        .grid       (grid),
        .location   (location),
        .cur_player (cur_player),
        .illegal    (illegal),
        .timeout    (timeout),
        .game_over  (game_over),
        .winner     (winner),
        .draw       (draw),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [97:0] grid;
        logic [6:0]  loc;
        logic [5:0]  cnt;
        logic [1:0]  player;
        logic        over;
        logic [1:0]  win;
        logic        drw;
        logic        ill;
    } exp_t;

    typedef struct {
        string       moves;
        logic [1:0]  win;
        logic [6:0]  loc;
        logic [5:0]  cnt;
        logic        drw;
    } game_t;

    exp_t  sb[$];
    game_t games[3];
    int    n_checks = 0;
    int    n_errors = 0;

    int mb[6][7];
    int mh[7];
    int mcnt, mplayer, mloc;
    bit mover, mdraw;
    int mwin;

    task automatic chk(input string nm, input logic [97:0] act, input logic [97:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic mdl_reset();
        for (int h = 0; h < 6; h++)
            for (int c = 0; c < 7; c++) mb[h][c] = 0;
        for (int c = 0; c < 7; c++) mh[c] = 0;
        mcnt = 0; mplayer = 2; mloc = 0; mover = 0; mdraw = 0; mwin = 0;
    endtask

    function automatic logic [97:0] mgrid();
        logic [97:0] g = '0;
        for (int h = 0; h < 6; h++)
            for (int c = 0; c < 7; c++) g[14 * h + 2 * c +: 2] = 2'(mb[h][c]);
        return g;
    endfunction

    function automatic bit mwins(input int h, input int c, input int p);
        for (int d = 0; d < 4; d++) begin
            int dh = (d == 0) ? 0 : 1;
            int dc = (d == 1) ? 0 : (d == 3) ? -1 : 1;
            int n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                int hh = h + s * dh;
                int cc = c + s * dc;
                while (hh >= 0 && hh < 6 && cc >= 0 && cc < 7 && mb[hh][cc] == p) begin
                    n++; hh += s * dh; cc += s * dc;
                end
            end
            if (n >= 4) return 1;
        end
        return 0;
    endfunction

    task automatic pulse_new_game();
        @(negedge clk); new_game = 1'b1;
        @(posedge clk); #1 new_game = 1'b0;
        mdl_reset();
    endtask

    task automatic play(input int col);
        exp_t e;
        bit legal;
        int h;
        legal = !mover && col < 7 && ((col < 7) ? mh[col] < 6 : 1'b0);
        e.ill = !mover && !legal;
        if (legal) begin
            h = mh[col];
            mb[h][col] = mplayer;
            mh[col]++;
            mcnt++;
            mloc = 14 * h + 2 * col + 1;
            if (mwins(h, col, mplayer)) begin mover = 1; mwin = mplayer; end
            else if (mcnt == 42) begin mover = 1; mdraw = 1; end
            else mplayer = 3 - mplayer;
        end
        e.grid = mgrid(); e.loc = 7'(mloc); e.cnt = 6'(mcnt); e.player = 2'(mplayer);
        e.over = mover; e.win = 2'(mwin); e.drw = mdraw;
        sb.push_back(e);
        @(negedge clk); move_valid = 1'b1; move_col = 3'(col);
        @(posedge clk); #1 move_valid = 1'b0;
        if (legal) begin
            repeat (2) @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        chk("grid", grid, e.grid);
        chk("location", 98'(location), 98'(e.loc));
        chk("move_count", 98'(move_count), 98'(e.cnt));
        chk("cur_player", 98'(cur_player), 98'(e.player));
        chk("game_over", 98'(game_over), 98'(e.over));
        chk("winner", 98'(winner), 98'(e.win));
        chk("draw", 98'(draw), 98'(e.drw));
        chk("illegal", 98'(illegal), 98'(e.ill));
        chk("move_ready", 98'(move_ready), 98'(!e.over));
    endtask

    initial begin
        games[0] = '{"0101010", 2'b10, 7'd43, 6'd7, 1'b0};
        games[1] = '{"0011223", 2'b10, 7'd7, 6'd7, 1'b0};
        games[2] = '{"022222200000133333311111466666644444555555", 2'b00, 7'd81, 6'd42, 1'b1};
        mdl_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_grid", grid, '0);
        chk("rst_location", 98'(location), 98'd0);
        chk("rst_count", 98'(move_count), 98'd0);
        chk("rst_player", 98'(cur_player), 98'b10);
        chk("rst_ready", 98'(move_ready), 98'd1);
        chk("rst_flags", 98'({illegal, timeout, game_over, draw, winner}), 98'd0);

        for (int g = 0; g < 3; g++) begin
            pulse_new_game();
            for (int i = 0; i < games[g].moves.len(); i++) play(int'(games[g].moves[i]) - 48);
            chk("tbl_winner", 98'(winner), 98'(games[g].win));
            chk("tbl_location", 98'(location), 98'(games[g].loc));
            chk("tbl_count", 98'(move_count), 98'(games[g].cnt));
            chk("tbl_draw", 98'(draw), 98'(games[g].drw));
            chk("tbl_over", 98'(game_over), 98'd1);
            if (g == 1) begin
                play(4);
                play(7);
            end
        end

        @(negedge clk); new_game = 1'b1;
        @(posedge clk); #1 new_game = 1'b0;
        mdl_reset();
        chk("ng_player", 98'(cur_player), 98'b10);
        chk("ng_over", 98'(game_over), 98'd0);
        chk("ng_draw", 98'(draw), 98'd0);
        chk("ng_grid", grid, '0);
        chk("ng_count", 98'(move_count), 98'd0);

        for (int i = 0; i < 6; i++) play(2);
        play(2);
        play(7);
        chk("full_player", 98'(cur_player), 98'b10);
        chk("full_count", 98'(move_count), 98'd6);

        pulse_new_game();
        @(negedge clk); move_valid = 1'b1; move_col = 3'd3;
        @(posedge clk); #1 move_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grid", grid, '0);
        chk("arst_ready", 98'(move_ready), 98'd1);
        chk("arst_count", 98'(move_count), 98'd0);
        @(negedge clk) rst_n = 1'b1;
        mdl_reset();

        pulse_new_game();
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            chk("to_early", 98'(timeout), 98'd0);
        end
        @(posedge clk); #1;
        chk("to_pulse", 98'(timeout), 98'd1);
        chk("to_player", 98'(cur_player), 98'b01);
        chk("to_grid", grid, '0);
        chk("to_count", 98'(move_count), 98'd0);
        @(posedge clk); #1;
        chk("to_oneshot", 98'(timeout), 98'd0);

        pulse_new_game();
        repeat (15) @(posedge clk);
        #1 move_valid = 1'b1; move_col = 3'd3;
        @(posedge clk); #1 move_valid = 1'b0;
        chk("to_race_timeout", 98'(timeout), 98'd0);
        chk("to_race_count", 98'(move_count), 98'd1);
        chk("to_race_ready", 98'(move_ready), 98'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("to_race_player", 98'(cur_player), 98'b01);
        chk("to_race_cell", 98'(grid[7 -: 2]), 98'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end
endmodule
